// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: arbiter states, access size codes,
// the latched request record and the default timeout depth.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_DACC = 2'd1,
      ARB_IACC = 2'd2,
      ARB_HALT = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   localparam int MAX_WAIT_DEFAULT = 255;

   localparam logic GRANT_DATA  = 1'b1;
   localparam logic GRANT_FETCH = 1'b0;

   // Request fields captured at the grant edge and held for the whole access.
   typedef struct packed {
      logic [31:0] wdata;
      size_t       size;
      logic        unsign;
      logic        we;
   } req_t;

   // Byte wins over half when the decode raises both.
   function automatic size_t decode_size(input logic by, input logic half);
      size_t sz;
      if (by) begin
         sz = SZ_BYTE;
      end else if (half) begin
         sz = SZ_HALF;
      end else begin
         sz = SZ_WORD;
      end
      return sz;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit port: store byte enables/replication and load extraction/extension.
// Purely combinational, no handshake.
module mem_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        unsign,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_al,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata[{off, 3'b000} +: 8];
   assign half_sel = rdata[{off[1], 4'b0000} +: 16];

   always_comb begin
      be        = 4'b1111;
      wdata_al  = wdata;
      rdata_ext = rdata;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << off;
            wdata_al  = {4{wdata[7:0]}};
            rdata_ext = {{24{~unsign & byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            be        = 4'b0011 << {off[1], 1'b0};
            wdata_al  = {2{wdata[15:0]}};
            rdata_ext = {{16{~unsign & half_sel[15]}}, half_sel};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data stages onto one memory port; ack is combinational with mem_ready, 1-cycle min after grant.
// Requesters hold until ack; stall covers outstanding data; a wait counter forces completion after MAX_WAIT cycles.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ack,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic              d_by,
   input  logic              d_half,
   input  logic              d_unsign,
   output logic [31:0]       d_rdata,
   output logic              d_ack,
   input  logic              halt,
   output logic              stall,
   output logic              timeout,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready
);

   localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

   arb_state_t        state, state_nxt;
   logic              grant_last;
   logic              ret_halt;
   logic [ADDR_W-1:0] lat_addr;
   req_t              lat_req;
   logic [CNT_W-1:0]  wait_cnt;

   logic              d_pend, allow_f, in_acc, expired, done;
   logic              grant_d, grant_f;
   logic [3:0]        al_be;
   logic [31:0]       al_wdata, al_rdata;

   assign d_pend  = d_read | d_write;
   assign in_acc  = (state == ARB_DACC) || (state == ARB_IACC);
   assign expired = (MAX_WAIT != 0) && (wait_cnt == CNT_W'(MAX_WAIT));
   assign done    = in_acc & (mem_ready | expired);

   assign d_ack  = done & (state == ARB_DACC);
   assign if_ack = done & (state == ARB_IACC);
   // Gated by reset so a requester still asserting during reset does not freeze the pipeline.
   assign stall  = rst_n & d_pend & ~d_ack;

   always_comb begin
      state_nxt = state;
      grant_d   = 1'b0;
      grant_f   = 1'b0;
      allow_f   = 1'b0;
      case (state)
         ARB_IDLE, ARB_HALT: begin
            allow_f = if_req & ~halt & (state == ARB_IDLE);
            if (d_pend && (!allow_f || grant_last == GRANT_FETCH)) begin
               state_nxt = ARB_DACC;
               grant_d   = 1'b1;
            end else if (allow_f) begin
               state_nxt = ARB_IACC;
               grant_f   = 1'b1;
            end else if (halt) begin
               state_nxt = ARB_HALT;
            end
         end
         ARB_DACC, ARB_IACC: begin
            if (done) begin
               state_nxt = (ret_halt | halt) ? ARB_HALT : ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         grant_last <= GRANT_DATA;
         ret_halt   <= 1'b0;
         lat_addr   <= '0;
         lat_req    <= '0;
         wait_cnt   <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         timeout    <= 1'b0;
      end else begin
         state <= state_nxt;

         if (grant_d) begin
            lat_addr       <= d_addr;
            lat_req.wdata  <= d_wdata;
            lat_req.size   <= decode_size(d_by, d_half);
            lat_req.unsign <= d_unsign;
            lat_req.we     <= d_write;
            ret_halt       <= (state == ARB_HALT);
         end else if (grant_f) begin
            lat_addr <= if_addr;
            lat_req  <= '{wdata: '0, size: SZ_WORD, unsign: 1'b0, we: 1'b0};
            ret_halt <= 1'b0;
         end

         if (done || !in_acc) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end

         // A forced completion returns zero data and latches the error.
         if (done) begin
            grant_last <= (state == ARB_DACC) ? GRANT_DATA : GRANT_FETCH;
            if (state == ARB_DACC) begin
               d_rdata <= mem_ready ? al_rdata : 32'h0;
            end else begin
               if_rdata <= mem_ready ? mem_rdata : 32'h0;
            end
            if (!mem_ready) begin
               timeout <= 1'b1;
            end
         end
      end
   end

   mem_lane_align u_align (
      .off       (lat_addr[1:0]),
      .size      (lat_req.size),
      .unsign    (lat_req.unsign),
      .wdata     (lat_req.wdata),
      .rdata     (mem_rdata),
      .be        (al_be),
      .wdata_al  (al_wdata),
      .rdata_ext (al_rdata)
   );

   assign mem_req   = in_acc;
   assign mem_we    = (state == ARB_DACC) & lat_req.we;
   assign mem_be    = !in_acc ? 4'h0 : (mem_we ? al_be : 4'hF);
   assign mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
   assign mem_wdata = al_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: random fetch/data traffic against a byte-level memory model,
// plus directed latency, store-lane, alternation, timeout, halt and reset scenarios.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_read, d_write;
   logic [31:0] d_addr, d_wdata;
   logic        d_by, d_half, d_unsign;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        halt;
   logic        stall, timeout;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_by(d_by), .d_half(d_half), .d_unsign(d_unsign), .d_rdata(d_rdata), .d_ack(d_ack),
      .halt(halt), .stall(stall), .timeout(timeout),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem_arr [0:127];
   logic [31:0] ref_arr [0:127];
   exp_t        dq[$];
   exp_t        iq[$];
   bit          ack_log[$];
   int          resp_mode = 0;   // 0 random latency, 1 immediate, 2 never ready

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] word, input int off, input int sz, input bit uns);
      logic [31:0] v;
      if (sz == 1) begin
         v = (word >> (8 * off)) & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
         v = (word >> (16 * (off / 2))) & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic logic [3:0] ref_be(input int sz, input int off);
      logic [3:0] b;
      b = 4'h0;
      for (int i = 0; i < 4; i++) begin
         if (sz == 4) b[i] = 1'b1;
         else if (sz == 2 && (i / 2) == (off / 2)) b[i] = 1'b1;
         else if (sz == 1 && i == off) b[i] = 1'b1;
      end
      return b;
   endfunction

   function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] w);
      logic [31:0] r;
      if (sz == 1) r = {4{w[7:0]}};
      else if (sz == 2) r = {2{w[15:0]}};
      else r = w;
      return r;
   endfunction

   // Memory responder: drives mem_ready/mem_rdata shortly after each edge and commits writes.
   int wait_left = 0;
   bit busy = 0;
   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
   end
   always @(posedge clk) begin
      #2;
      if (mem_req) begin
         if (!busy) begin
            busy = 1;
            wait_left = (resp_mode == 0) ? int'($urandom_range(0, 3)) : 0;
         end
         mem_ready = (resp_mode != 2) && (wait_left == 0);
         mem_rdata = mem_arr[mem_addr[8:2]];
         if (mem_ready && mem_we) begin
            for (int i = 0; i < 4; i++)
               if (mem_be[i]) mem_arr[mem_addr[8:2]][8*i +: 8] = mem_wdata[8*i +: 8];
         end
         if (wait_left > 0) wait_left--;
      end else begin
         busy = 0;
         mem_ready = 1'b0;
         mem_rdata = $urandom;
      end
   end

   // Monitor: pops the expected record whenever an ack appears; checks rdata one cycle later.
   exp_t dcur, icur;
   bit   d_chk_pend = 0, i_chk_pend = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (d_chk_pend) begin
            if (!dcur.we) chk("d_rdata", d_rdata, dcur.rdata);
            d_chk_pend = 0;
         end
         if (i_chk_pend) begin
            chk("if_rdata", if_rdata, icur.rdata);
            i_chk_pend = 0;
         end
         chk("ack_onehot", {31'h0, d_ack & if_ack}, 32'h0);
         if (!(d_read || d_write)) chk("stall_idle", {31'h0, stall}, 32'h0);
         if (d_ack) begin
            if (dq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_d_ack: got 1 expected 0 at %0t", $time);
            end else begin
               dcur = dq.pop_front();
               chk("d_mem_addr", mem_addr, dcur.addr);
               chk("d_mem_we", {31'h0, mem_we}, {31'h0, dcur.we});
               chk("d_mem_be", {28'h0, mem_be}, {28'h0, dcur.be});
               if (dcur.we) chk("d_mem_wdata", mem_wdata, dcur.wdata);
               d_chk_pend = 1;
               ack_log.push_back(1'b1);
            end
         end
         if (if_ack) begin
            if (iq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_if_ack: got 1 expected 0 at %0t", $time);
            end else begin
               icur = iq.pop_front();
               chk("i_mem_addr", mem_addr, icur.addr);
               chk("i_mem_we", {31'h0, mem_we}, 32'h0);
               chk("i_mem_be", {28'h0, mem_be}, 32'hF);
               i_chk_pend = 1;
               ack_log.push_back(1'b0);
            end
         end
      end
   end

   task automatic data_op(input bit wr, input int sz, input bit uns, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit tmo, output int lat);
      exp_t e;
      int   idx, off;
      idx = int'(addr[8:2]);
      off = int'(addr[1:0]);
      e.we    = wr;
      e.addr  = {addr[31:2], 2'b00};
      e.be    = wr ? ref_be(sz, off) : 4'hF;
      e.wdata = ref_wdata(sz, wdata);
      e.rdata = 32'h0;
      if (wr && !tmo) begin
         for (int i = 0; i < 4; i++)
            if (e.be[i]) ref_arr[idx][8*i +: 8] = e.wdata[8*i +: 8];
      end else if (!wr && !tmo) begin
         e.rdata = ref_load(ref_arr[idx], off, sz, uns);
      end
      dq.push_back(e);
      d_read = !wr; d_write = wr; d_addr = addr; d_wdata = wdata;
      d_by = (sz == 1); d_half = (sz == 2); d_unsign = uns;
      for (lat = 1; lat <= 40; lat++) begin
         @(negedge clk);
         if (d_ack) begin
            chk("stall_at_ack", {31'h0, stall}, 32'h0);
            break;
         end
         chk("stall_wait", {31'h0, stall}, 32'h1);
      end
      if (lat > 40) begin
         checks++; failures++;
         $display("FAIL d_ack_wait: got no ack expected ack within 40 cycles at %0t", $time);
      end
      @(posedge clk); #1;
      d_read = 0; d_write = 0; d_addr = $urandom; d_wdata = $urandom;
      d_by = 0; d_half = 0; d_unsign = 0;
   endtask

   task automatic fetch_op(input logic [31:0] addr, input bit tmo);
      exp_t e;
      int   n;
      e.we = 0; e.addr = addr; e.be = 4'hF; e.wdata = 32'h0;
      e.rdata = tmo ? 32'h0 : ref_arr[addr[8:2]];
      iq.push_back(e);
      if_req = 1; if_addr = addr;
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (if_ack) break;
      end
      if (n > 40) begin
         checks++; failures++;
         $display("FAIL if_ack_wait: got no ack expected ack within 40 cycles at %0t", $time);
      end
      @(posedge clk); #1;
      if_req = 0; if_addr = $urandom;
   endtask

   task automatic rand_data(input int gap_max);
      int lat, sz;
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      sz = (1 << $urandom_range(0, 2));
      data_op($urandom_range(0, 1), sz, $urandom_range(0, 1), 32'h100 + $urandom_range(0, 255),
              $urandom, 0, lat);
   endtask

   initial begin
      int lat;
      #300000;
      $display("FAIL watchdog: got no completion expected summary before 300us");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int lat;
      for (int i = 0; i < 128; i++) begin
         mem_arr[i] = $urandom;
         ref_arr[i] = mem_arr[i];
      end
      rst_n = 0; if_req = 0; if_addr = 0; d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
      d_by = 0; d_half = 0; d_unsign = 0; halt = 0;
      repeat (3) @(negedge clk);
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
      chk("rst_timeout", {31'h0, timeout}, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      @(posedge clk); #1; rst_n = 1;

      // Random concurrent traffic on both requesters.
      resp_mode = 0;
      fork
         for (int i = 0; i < 30; i++) rand_data(3);
         for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            fetch_op({24'h0, 2'b00, 6'($urandom_range(0, 63)), 2'b00} & 32'h0FC, 0);
         end
      join
      chk("timeout_clear", {31'h0, timeout}, 32'h0);

      // Signed byte load at lane 3 with an always-ready memory.
      resp_mode = 1;
      mem_arr[64] = 32'h8000_0000; ref_arr[64] = 32'h8000_0000;
      data_op(0, 1, 0, 32'h103, 32'h0, 0, lat);
      chk("load_latency", lat, 2);
      chk("load_byte_ext", d_rdata, 32'hFFFF_FF80);

      // Halfword store into upper lanes.
      data_op(1, 2, 0, 32'h202 & 32'h1FF | 32'h100, 32'h0000_BEEF, 0, lat);
      chk("store_latency", lat, 2);

      // Both requesters back to back: acks must alternate.
      resp_mode = 0;
      ack_log.delete();
      fork
         for (int i = 0; i < 8; i++) data_op(0, 4, 0, 32'h100 + 4 * i, 32'h0, 0, lat);
         for (int i = 0; i < 8; i++) fetch_op(32'h40 + 4 * i, 0);
      join
      chk("alt_count", ack_log.size(), 16);
      for (int i = 1; i < ack_log.size(); i++)
         chk("alternate", {31'h0, ack_log[i] != ack_log[i-1]}, 32'h1);

      // Memory never answers: forced completion after MAX_WAIT idle cycles.
      resp_mode = 2;
      data_op(0, 4, 0, 32'h110, 32'h0, 1, lat);
      chk("tmo_latency", lat, 6);
      chk("tmo_flag", {31'h0, timeout}, 32'h1);
      resp_mode = 0;
      data_op(0, 2, 1, 32'h116, 32'h0, 0, lat);
      chk("tmo_sticky", {31'h0, timeout}, 32'h1);

      // Halt with a pending fetch: no fetch grant, data still served, halt persists.
      halt = 1; if_req = 1; if_addr = 32'h20;
      repeat (6) begin
         @(negedge clk);
         chk("halt_no_req", {31'h0, mem_req}, 32'h0);
      end
      @(posedge clk); #1;
      resp_mode = 1;
      data_op(0, 1, 1, 32'h121, 32'h0, 0, lat);
      chk("halt_d_latency", lat, 2);
      halt = 0;
      repeat (6) begin
         @(negedge clk);
         chk("halted_no_fetch", {31'h0, mem_req | if_ack}, 32'h0);
      end

      // Asynchronous reset in the middle of a stalled store.
      @(posedge clk); #1;
      if_req = 0; resp_mode = 2;
      d_write = 1; d_addr = 32'h180; d_wdata = 32'h1234_5678;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
      chk("pre_rst_we", {31'h0, mem_we}, 32'h1);
      #2 rst_n = 0;
      #1;
      chk("arst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("arst_mem_we", {31'h0, mem_we}, 32'h0);
      chk("arst_mem_be", {28'h0, mem_be}, 32'h0);
      chk("arst_stall", {31'h0, stall}, 32'h0);
      chk("arst_d_ack", {31'h0, d_ack}, 32'h0);
      chk("arst_timeout", {31'h0, timeout}, 32'h0);
      d_write = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      chk("post_rst_req", {31'h0, mem_req}, 32'h0);
      chk("post_rst_d_rdata", d_rdata, 32'h0);
      chk("post_rst_if_rdata", if_rdata, 32'h0);
      chk("post_rst_ack", {30'h0, d_ack, if_ack}, 32'h0);
      @(posedge clk); #1;
      resp_mode = 0;
      fetch_op(32'h8, 0);
      rand_data(1);
      repeat (3) @(negedge clk);
      chk("queues_empty", dq.size() + iq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
